y_drain: RTL and testbench
==========================

Y_DRAIN -- requirements
Module: y_drain

Interface
REQ-001 Parameter N, default 3: systolic array dimension; results form an N x N matrix.
REQ-002 Parameter ACC_W, default 32: width of one accumulated result.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en_y  input  1  result-ready level from the upstream counter; may stay high for several cycles.
REQ-006 y_in  input  N*N*ACC_W  flattened result matrix; element (r,c) is at bits [(r*N+c)*ACC_W +: ACC_W].
REQ-007 clr_ovr  input  1  synchronous clear of the overrun flag.
REQ-008 out_valid  output  1  out_data holds a valid element.
REQ-009 out_ready  input  1  consumer accepts the element this cycle.
REQ-010 out_data  output  ACC_W  current element.
REQ-011 out_row, out_col  output  $clog2(N) each  coordinates of the current element.
REQ-012 out_last  output  1  current element is (N-1,N-1).
REQ-013 busy  output  1  high while a matrix is held or draining.
REQ-014 overrun  output  1  sticky flag: a capture request arrived while busy and was dropped.

Function
REQ-015 The block SHALL register en_y and detect a rising edge: en_y=1 this cycle and 0 in the previous cycle.
REQ-016 The FSM SHALL have two states: IDLE (out_valid=0, busy=0) and DRAIN (out_valid=1, busy=1).
REQ-017 In IDLE, a rising edge SHALL capture all of y_in into an internal N*N buffer, reset the index to (0,0) and enter DRAIN on the same clock edge; out_valid SHALL be 1 in the next cycle.
REQ-018 A handshake SHALL occur when out_valid and out_ready are both 1; each handshake SHALL advance the index in row-major order (col increments, then wraps to 0 with row+1).
REQ-019 A handshake with out_last=1 SHALL return the FSM to IDLE, unless REQ-021 applies.
REQ-020 A rising edge in DRAIN without a final handshake in the same cycle SHALL set overrun; the buffer and index SHALL remain unchanged.
REQ-021 A rising edge coinciding with the final handshake SHALL be accepted: a new capture, index (0,0), FSM stays in DRAIN, overrun unchanged.
REQ-022 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last SHALL hold stable.
REQ-023 Changes on y_in after capture SHALL NOT affect out_data.
REQ-024 clr_ovr=1 SHALL clear overrun on the next edge; if a set condition occurs in the same cycle, set SHALL win.
REQ-025 out_data SHALL be the buffered element (out_row,out_col); out_last = (out_row==N-1 && out_col==N-1) && out_valid.
REQ-026 A level of en_y held high SHALL produce exactly one capture.

Reset
REQ-027 reset=1 SHALL immediately force: FSM=IDLE, out_valid=0, busy=0, overrun=0, out_last=0, index=(0,0), registered en_y=0, out_data=0.
REQ-028 Reset asserted mid-drain SHALL abandon the matrix; no further elements SHALL be emitted.
REQ-029 If en_y is already high when reset releases, it SHALL count as a rising edge on the first clock after release.

Structure
REQ-030 Shared package systolic_pkg SHALL hold N, ACC_W defaults and the drain state enum (IDLE, DRAIN).
REQ-031 Edge detection SHALL be a sub-module rise_detect (clk, reset, d, rise).
REQ-032 The buffer SHALL be a flop array; no memory macros.

Verification
REQ-033 Load y_in with element (r,c) = 10*r+c, pulse en_y, out_ready=1 -> 9 consecutive outputs 0,1,2,10,11,12,20,21,22; out_last only on 22; then busy=0.
REQ-034 Same load, out_ready toggled 1,0 each cycle -> same 9 values, each held stable while out_ready=0, total 18 cycles.
REQ-035 en_y held high 20 cycles -> exactly one 9-element drain, overrun=0.
REQ-036 Second en_y rise at element 4 -> overrun=1, sequence 0..22 unaltered; clr_ovr -> overrun=0 next cycle.
REQ-037 Second en_y rise in the same cycle as the final handshake, with new y_in = 100+value -> immediate second drain 100..122, overrun=0.
REQ-038 Reset asserted after 3 handshakes -> out_valid=0 and busy=0 without waiting for a clock edge; the next en_y rise restarts at (0,0).

Source files
------------

// File: rtl/systolic_pkg.sv
// Shared definitions for the systolic-array result path: default array
// geometry and the drain state machine encoding.
package systolic_pkg;

   // Default array dimension (results form a DEF_N x DEF_N matrix).
   localparam int DEF_N     = 3;
   // Default width of one accumulated result.
   localparam int DEF_ACC_W = 32;

   // Drain FSM: IDLE waits for a capture, DRAIN streams the held matrix.
   typedef enum logic {
      IDLE  = 1'b0,
      DRAIN = 1'b1
   } drain_state_t;

   // Width of a row/column index. The floor of 1 keeps a degenerate
   // 1x1 array from producing a zero-width vector.
   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage : systolic_pkg

// File: rtl/rise_detect.sv
// Rising-edge detector. It registers d once, and rise is high in any cycle
// where d is 1 now and was 0 in the previous cycle. Reset clears the
// history, so a d already high at reset release reads as a fresh edge.
module rise_detect (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic rise
);

   logic d_q;

   // Remember the previous-cycle level of d.
   // NOTE: clocked state uses non-blocking (<=). Every flop then sees
   // values from before the edge, whatever the order the blocks run in.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         d_q <= 1'b0;
      end else begin
         d_q <= d;
      end
   end

   assign rise = d & ~d_q;

endmodule : rise_detect

// File: rtl/y_drain.sv
// Result drain for an N x N systolic array. A rising edge on en_y
// snapshots the whole result matrix into a local flop buffer. The block
// then streams the matrix one element at a time in row-major order over a
// valid/ready handshake. If a capture request arrives while a matrix is
// still draining, the request is dropped and a sticky overrun flag is set.
// The one exception is a request that lands on the final handshake: it is
// accepted and a new drain starts back to back.
module y_drain
   import systolic_pkg::*;
#(
   parameter  int N     = DEF_N,
   parameter  int ACC_W = DEF_ACC_W,
   localparam int IDX_W = idx_width(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en_y,
   input  logic [N*N*ACC_W-1:0] y_in,
   input  logic                 clr_ovr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ACC_W-1:0]     out_data,
   output logic [IDX_W-1:0]     out_row,
   output logic [IDX_W-1:0]     out_col,
   output logic                 out_last,
   output logic                 busy,
   output logic                 overrun
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

   drain_state_t     state;
   logic [ACC_W-1:0] buffer [N][N];

   logic             rise;
   logic             handshake;
   logic             final_hs;
   logic             capture;
   logic             drop;
   logic [IDX_W-1:0] next_row;
   logic [IDX_W-1:0] next_col;

   // Edge detection on the upstream result-ready level. A level held high
   // therefore yields exactly one capture request.
   rise_detect u_rise (
      .clk   (clk),
      .reset (reset),
      .d     (en_y),
      .rise  (rise)
   );

   // Handshake qualification and capture/drop arbitration. A capture is
   // accepted when idle, or when the final element leaves in that cycle.
   // Any other request during a drain is a dropped request.
   assign handshake = out_valid & out_ready;
   assign final_hs  = handshake & out_last;
   assign capture   = rise & ((state == IDLE) | final_hs);
   assign drop      = rise & (state == DRAIN) & ~final_hs;

   // Row-major successor of the current index.
   // NOTE: every output of this block gets a default before any branch.
   // Otherwise a path that skips an assignment infers a latch.
   always_comb begin
      next_row = out_row;
      next_col = out_col + IDX_W'(1);
      if (out_col == LAST_IDX) begin
         next_col = '0;
         next_row = out_row + IDX_W'(1);
      end
   end

   // Snapshot of the result matrix. Later changes on y_in cannot reach
   // the output stream.
   // NOTE: the buffer has no reset. Its contents are only read after a
   // capture has written every element, so clearing it would add reset
   // fan-out and buy nothing.
   always_ff @(posedge clk) begin
      if (capture) begin
         for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
               buffer[r][c] <= y_in[(r*N + c)*ACC_W +: ACC_W];
            end
         end
      end
   end

   // Drain FSM. The state, index and every stream output are registered,
   // so the outputs stay stable while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         out_last  <= 1'b0;
         out_row   <= '0;
         out_col   <= '0;
         out_data  <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (capture) begin
                  state     <= DRAIN;
                  out_valid <= 1'b1;
                  busy      <= 1'b1;
                  out_row   <= '0;
                  out_col   <= '0;
                  out_data  <= y_in[ACC_W-1:0];
                  out_last  <= (N == 1);
               end
            end
            DRAIN: begin
               if (capture) begin
                  // Back-to-back matrix: restart at (0,0) straight from y_in.
                  // The buffer is loaded on this same edge.
                  out_row   <= '0;
                  out_col   <= '0;
                  out_data  <= y_in[ACC_W-1:0];
                  out_last  <= (N == 1);
               end else if (final_hs) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  out_last  <= 1'b0;
                  out_row   <= '0;
                  out_col   <= '0;
                  out_data  <= '0;
               end else if (handshake) begin
                  out_row   <= next_row;
                  out_col   <= next_col;
                  out_data  <= buffer[next_row][next_col];
                  out_last  <= (next_row == LAST_IDX) && (next_col == LAST_IDX);
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
               busy      <= 1'b0;
               out_last  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun flag. A dropped request in the same cycle as a clear
   // leaves the flag set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overrun <= 1'b0;
      end else if (drop) begin
         overrun <= 1'b1;
      end else if (clr_ovr) begin
         overrun <= 1'b0;
      end
   end

endmodule : y_drain

// File: tb/tb_y_drain.sv
// Self-checking bench for y_drain (N=3, ACC_W=32). A queue-based model
// predicts the element stream. Directed tables and sequences exercise the
// documented scenarios, and a randomized phase follows.
module tb_y_drain;

   localparam int N     = 3;
   localparam int ACC_W = 32;
   localparam int IDX_W = 2;

   logic                 clk = 1'b0;
   logic                 reset;
   logic                 en_y;
   logic [N*N*ACC_W-1:0] y_in;
   logic                 clr_ovr;
   logic                 out_valid;
   logic                 out_ready;
   logic [ACC_W-1:0]     out_data;
   logic [IDX_W-1:0]     out_row;
   logic [IDX_W-1:0]     out_col;
   logic                 out_last;
   logic                 busy;
   logic                 overrun;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   y_drain #(.N(N), .ACC_W(ACC_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .en_y      (en_y),
      .y_in      (y_in),
      .clr_ovr   (clr_ovr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_row   (out_row),
      .out_col   (out_col),
      .out_last  (out_last),
      .busy      (busy),
      .overrun   (overrun)
   );

   // ---------------- reference model ----------------
   typedef struct {
      logic [ACC_W-1:0] d;
      int               r;
      int               c;
   } elem_t;

   elem_t q[$];          // elements still to be delivered, head = current
   bit    m_prev_en;
   bit    m_ovr;

   task automatic model_reset();
      q.delete();
      m_prev_en = 1'b0;
      m_ovr     = 1'b0;
   endtask

   // One clock edge, evaluated with the inputs that were present before it.
   task automatic model_update();
      bit have, hs, fin, rise, set;
      have = (q.size() > 0);
      hs   = have && out_ready;
      fin  = hs && (q.size() == 1);
      rise = en_y && !m_prev_en;
      set  = 1'b0;
      m_prev_en = en_y;
      if (hs) void'(q.pop_front());
      if (rise) begin
         if (!have || fin) begin
            q.delete();
            for (int r = 0; r < N; r++)
               for (int c = 0; c < N; c++)
                  q.push_back('{d: y_in[(r*N + c)*ACC_W +: ACC_W], r: r, c: c});
         end else begin
            set = 1'b1;
         end
      end
      if (set)          m_ovr = 1'b1;
      else if (clr_ovr) m_ovr = 1'b0;
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic compare_model();
      bit v;
      v = (q.size() > 0);
      check("model valid",   out_valid, v);
      check("model busy",    busy,      v);
      check("model last",    out_last,  q.size() == 1);
      check("model overrun", overrun,   m_ovr);
      if (v) begin
         check("model data", out_data, q[0].d);
         check("model row",  out_row,  q[0].r);
         check("model col",  out_col,  q[0].c);
      end
   endtask

   // Advance one clock: update the model at the edge, then compare 1 time
   // unit later. Inputs are changed by the caller only after this returns.
   task automatic cycle();
      @(posedge clk);
      if (reset) model_reset();
      else       model_update();
      #1;
      compare_model();
   endtask

   // Handshaked values observed by the directed sequences.
   logic [ACC_W-1:0] got_q[$];

   task automatic step_collect();
      if (out_valid && out_ready) got_q.push_back(out_data);
      cycle();
   endtask

   task automatic load_pattern(input int base);
      for (int r = 0; r < N; r++)
         for (int c = 0; c < N; c++)
            y_in[(r*N + c)*ACC_W +: ACC_W] = ACC_W'(base + 10*r + c);
   endtask

   // Compare collected handshakes against one or two base-pattern matrices.
   task automatic check_seq(input string name, input int nmat, input int base2);
      logic [ACC_W-1:0] exp[$];
      for (int m = 0; m < nmat; m++)
         for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
               exp.push_back(ACC_W'(((m == 0) ? 0 : base2) + 10*r + c));
      check({name, " count"}, got_q.size(), exp.size());
      for (int i = 0; i < exp.size() && i < got_q.size(); i++)
         check({name, " value"}, got_q[i], exp[i]);
   endtask

   // ---------------- directed table ----------------
   typedef struct {
      logic             en;
      logic             rdy;
      logic             exp_valid;
      logic             exp_last;
      logic             exp_busy;
      logic [ACC_W-1:0] exp_data;
      logic [IDX_W-1:0] exp_row;
      logic [IDX_W-1:0] exp_col;
   } vec_t;

   vec_t vecs[11];

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   initial begin : main
      // Basic drain: capture on the en_y edge, then nine handshakes.
      vecs[0] = '{en: 1'b1, rdy: 1'b1, exp_valid: 1'b1, exp_last: 1'b0, exp_busy: 1'b1,
                  exp_data: 32'd0, exp_row: 2'd0, exp_col: 2'd0};
      for (int k = 1; k < 9; k++)
         vecs[k] = '{en: 1'b0, rdy: 1'b1, exp_valid: 1'b1, exp_last: (k == 8), exp_busy: 1'b1,
                     exp_data: ACC_W'(10*(k/3) + (k%3)), exp_row: IDX_W'(k/3), exp_col: IDX_W'(k%3)};
      vecs[9]  = '{en: 1'b0, rdy: 1'b1, exp_valid: 1'b0, exp_last: 1'b0, exp_busy: 1'b0,
                   exp_data: 32'd0, exp_row: 2'd0, exp_col: 2'd0};
      vecs[10] = '{en: 1'b0, rdy: 1'b1, exp_valid: 1'b0, exp_last: 1'b0, exp_busy: 1'b0,
                   exp_data: 32'd0, exp_row: 2'd0, exp_col: 2'd0};

      reset = 1'b1; en_y = 1'b0; clr_ovr = 1'b0; out_ready = 1'b0;
      load_pattern(0);
      model_reset();
      #1;
      compare_model();
      check("reset data", out_data, 0);
      check("reset row",  out_row,  0);
      check("reset col",  out_col,  0);
      cycle();
      cycle();
      reset = 1'b0;
      cycle();

      for (int i = 0; i < 11; i++) begin
         en_y = vecs[i].en;
         out_ready = vecs[i].rdy;
         cycle();
         check($sformatf("vec%0d valid", i), out_valid, vecs[i].exp_valid);
         check($sformatf("vec%0d last",  i), out_last,  vecs[i].exp_last);
         check($sformatf("vec%0d busy",  i), busy,      vecs[i].exp_busy);
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d data", i), out_data, vecs[i].exp_data);
            check($sformatf("vec%0d row",  i), out_row,  vecs[i].exp_row);
            check($sformatf("vec%0d col",  i), out_col,  vecs[i].exp_col);
         end
      end

      // Consumer stalls every other cycle: 18 drain cycles for 9 elements.
      got_q.delete();
      en_y = 1'b1; out_ready = 1'b1;
      step_collect();
      en_y = 1'b0;
      for (int k = 0; k < 18; k++) begin
         out_ready = k[0];
         step_collect();
      end
      check("toggle busy after 18", busy, 0);
      check_seq("toggle seq", 1, 0);

      // en_y level held for 20 cycles yields a single drain.
      got_q.delete();
      en_y = 1'b1; out_ready = 1'b1;
      repeat (20) step_collect();
      en_y = 1'b0;
      repeat (5) step_collect();
      check_seq("level seq", 1, 0);
      check("level overrun", overrun, 0);

      // Second request mid-drain is dropped and flags overrun.
      got_q.delete();
      en_y = 1'b1;
      step_collect();
      en_y = 1'b0;
      repeat (4) step_collect();
      check("mid element 4", out_data, 11);
      en_y = 1'b1;
      step_collect();
      en_y = 1'b0;
      repeat (8) step_collect();
      check("overrun set", overrun, 1);
      check_seq("overrun seq", 1, 0);
      clr_ovr = 1'b1;
      cycle();
      clr_ovr = 1'b0;
      check("overrun cleared", overrun, 0);

      // Request on the final handshake starts a back-to-back drain.
      got_q.delete();
      load_pattern(0);
      en_y = 1'b1;
      step_collect();
      en_y = 1'b0;
      repeat (8) step_collect();
      load_pattern(100);
      en_y = 1'b1;
      step_collect();
      en_y = 1'b0;
      check("b2b restart data", out_data, 100);
      check("b2b restart valid", out_valid, 1);
      repeat (10) step_collect();
      check_seq("b2b seq", 2, 100);
      check("b2b overrun", overrun, 0);
      check("b2b busy end", busy, 0);

      // Asynchronous reset mid-drain, then a clean restart.
      load_pattern(0);
      en_y = 1'b1;
      cycle();
      en_y = 1'b0;
      repeat (3) cycle();
      reset = 1'b1;
      model_reset();
      #1;
      check("async reset valid", out_valid, 0);
      check("async reset busy",  busy,      0);
      cycle();
      reset = 1'b0;
      cycle();
      check("post reset idle", out_valid, 0);
      en_y = 1'b1;
      cycle();
      en_y = 1'b0;
      check("restart data", out_data, 0);
      check("restart row",  out_row,  0);
      check("restart col",  out_col,  0);
      repeat (10) cycle();

      // en_y already high when reset releases counts as an edge.
      en_y = 1'b1;
      reset = 1'b1;
      model_reset();
      cycle();
      reset = 1'b0;
      cycle();
      check("release edge valid", out_valid, 1);
      en_y = 1'b0;
      repeat (10) cycle();

      // Randomized traffic against the model. y_in is scrambled every cycle.
      for (int k = 0; k < 600; k++) begin
         if ($urandom_range(0, 5) == 0) en_y = ~en_y;
         out_ready = ($urandom_range(0, 3) != 0);
         clr_ovr   = ($urandom_range(0, 15) == 0);
         for (int i = 0; i < N*N; i++) y_in[i*ACC_W +: ACC_W] = $urandom;
         if ($urandom_range(0, 149) == 0) begin
            reset = 1'b1;
            model_reset();
            #1;
            compare_model();
            cycle();
            reset = 1'b0;
         end
         cycle();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_y_drain
